// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - emulated bouncing mechanical switch driven by a clean level
module switch_bounce_gen #(
    parameter int unsigned TICK_M       = 100_000,
    parameter int unsigned MAX_BOUNCE   = 7,
    parameter int unsigned SETTLE_TICKS = 50,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    input  logic bounce_en,
    output logic sw,
    output logic busy,
    output logic done
);

    localparam int unsigned CW   = $clog2(TICK_M);
    localparam int unsigned SW_W = $clog2(SETTLE_TICKS + 1);

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0]     SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TICK_M - 1);
    localparam logic [3:0]      MAXB      = 4'(MAX_BOUNCE);
    localparam logic [SW_W-1:0] SETTLE_LD = SW_W'(SETTLE_TICKS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BON    = 2'd1;
    localparam logic [1:0] S_BOFF   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [CW-1:0]   cnt_q;
    logic [15:0]     lfsr_q;
    logic [1:0]      state_q,  state_d;
    logic            level_q,  level_d;
    logic            target_q, target_d;
    logic [3:0]      n_q,      n_d;
    logic [2:0]      dwell_q,  dwell_d;
    logic [SW_W-1:0] settle_q, settle_d;
    logic            sw_q,     sw_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic       tick;
    logic       lfsr_fb;
    logic [3:0] n_start;
    logic [2:0] dwell_ld;

    assign tick     = (cnt_q == CNT_LAST);
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign n_start  = bounce_en ? ((lfsr_q[3:0] > MAXB) ? MAXB : lfsr_q[3:0]) : 4'd0;
    assign dwell_ld = {1'b0, lfsr_q[1:0]} + 3'd1;

    // Free-running tick prescaler; never restarted by a transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Pseudo-random source for bounce count and dwell lengths, advanced once per tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else if (tick) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // Transition sequencer: start, bounce on/off phases, settle, then report done.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        n_d      = n_q;
        dwell_d  = dwell_q;
        settle_d = settle_q;
        sw_d     = sw_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_in != level_q) begin
                    target_d = level_in;
                    sw_d     = level_in;
                    n_d      = n_start;
                    if (n_start != 4'd0) begin
                        state_d = S_BON;
                        dwell_d = dwell_ld;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = SETTLE_LD;
                    end
                end
            end
            S_BON: begin
                if (tick) begin
                    if (dwell_q == 3'd1) begin
                        if (n_q != 4'd0) begin
                            state_d = S_BOFF;
                            sw_d    = ~target_q;
                            dwell_d = dwell_ld;
                        end else begin
                            state_d  = S_SETTLE;
                            sw_d     = target_q;
                            settle_d = SETTLE_LD;
                        end
                    end else begin
                        dwell_d = dwell_q - 3'd1;
                    end
                end
            end
            S_BOFF: begin
                if (tick) begin
                    if (dwell_q == 3'd1) begin
                        state_d = S_BON;
                        sw_d    = target_q;
                        n_d     = n_q - 4'd1;
                        dwell_d = dwell_ld;
                    end else begin
                        dwell_d = dwell_q - 3'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (settle_q == SW_W'(1)) begin
                        state_d = S_IDLE;
                        level_d = target_q;
                        done_d  = 1'b1;
                    end else begin
                        settle_d = settle_q - SW_W'(1);
                    end
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs; reset aborts any transition silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            level_q  <= 1'b0;
            target_q <= 1'b0;
            n_q      <= 4'd0;
            dwell_q  <= 3'd0;
            settle_q <= '0;
            sw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            n_q      <= n_d;
            dwell_q  <= dwell_d;
            settle_q <= settle_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sw   = sw_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - scoreboard bench for switch_bounce_gen
`timescale 1ns/1ps
module tb_switch_bounce_gen;

    localparam int TICK_M       = 4;
    localparam int SETTLE_TICKS = 3;
    localparam int MAXB_A       = 7;
    localparam int MAXB_B       = 0;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int LTAB         = 16384;
    localparam int IDLE_LIMIT   = 3000;

    typedef struct { int e; logic v; } ev_t;
    typedef struct { int e; int tog; } dn_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic level_in  = 1'b0;
    logic bounce_en = 1'b0;
    logic sw_a, busy_a, done_a;
    logic sw_b, busy_b, done_b;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   e        = 0;
    bit   rst_flag = 1'b1;
    logic [15:0] ltab [LTAB];
    ev_t  swq [2][$];
    dn_t  dq  [2][$];
    bit   m_busy   [2];
    logic m_level  [2];
    logic m_tgt    [2];
    int   m_done_e [2];
    int   m_tog    [2];
    logic prev_sw  [2];
    int   tog      [2];

    always #5 clk = ~clk;

    switch_bounce_gen #(.TICK_M(TICK_M), .MAX_BOUNCE(MAXB_A), .SETTLE_TICKS(SETTLE_TICKS), .SEED(SEED)) u_dut_a (
        .clk(clk), .reset(reset), .level_in(level_in), .bounce_en(bounce_en),
        .sw(sw_a), .busy(busy_a), .done(done_a)
    );

    switch_bounce_gen #(.TICK_M(TICK_M), .MAX_BOUNCE(MAXB_B), .SETTLE_TICKS(SETTLE_TICKS), .SEED(SEED)) u_dut_b (
        .clk(clk), .reset(reset), .level_in(level_in), .bounce_en(bounce_en),
        .sw(sw_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d at edge %0d: got %0d expected %0d", name, idx, e, act, exp);
    endtask

    // LFSR value in force just before clock edge number edge_n (edges counted from reset release).
    function automatic logic [15:0] lfsr_before(input int edge_n);
        int k;
        k = (edge_n - 1) / TICK_M;
        if (k >= LTAB) k = LTAB - 1;
        return ltab[k];
    endfunction

    // Edge of the d-th tick strictly after edge ent; ticks fall on edges that are multiples of TICK_M.
    function automatic int tick_after(input int ent, input int d);
        return (ent / TICK_M + d) * TICK_M;
    endfunction

    task automatic push_sw(input int idx, input int edge_n, input logic v);
        ev_t ev;
        ev.e = edge_n;
        ev.v = v;
        swq[idx].push_back(ev);
        m_tog[idx]++;
    endtask

    // Predict the whole waveform of one transition starting at edge e0.
    task automatic plan(input int idx, input int e0, input logic tgt, input logic ben);
        logic [15:0] l;
        int maxb, n, ent, d;
        dn_t dn;
        maxb = (idx == 0) ? MAXB_A : MAXB_B;
        l = lfsr_before(e0);
        n = ben ? ((int'(l[3:0]) < maxb) ? int'(l[3:0]) : maxb) : 0;
        m_tog[idx] = 0;
        push_sw(idx, e0, tgt);
        ent = e0;
        if (n > 0) begin
            for (int g = 0; g <= n; g++) begin
                l = lfsr_before(ent);
                d = 1 + int'(l[1:0]);
                ent = tick_after(ent, d);
                if (g < n) begin
                    push_sw(idx, ent, ~tgt);
                    l = lfsr_before(ent);
                    d = 1 + int'(l[1:0]);
                    ent = tick_after(ent, d);
                    push_sw(idx, ent, tgt);
                end
            end
        end
        m_done_e[idx] = tick_after(ent, SETTLE_TICKS);
        dn.e   = m_done_e[idx];
        dn.tog = m_tog[idx];
        dq[idx].push_back(dn);
        m_busy[idx] = 1'b1;
        m_tgt[idx]  = tgt;
    endtask

    // Reference model: advances on every rising edge using the inputs present at that edge.
    initial begin
        ltab[0] = SEED;
        for (int k = 1; k < LTAB; k++)
            ltab[k] = (ltab[k-1] << 1) | 16'(ltab[k-1][15] ^ ltab[k-1][13] ^ ltab[k-1][12] ^ ltab[k-1][10]);
        forever begin
            @(posedge clk);
            if (reset) begin
                e = 0;
                rst_flag = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    swq[i].delete();
                    dq[i].delete();
                    m_busy[i]  = 1'b0;
                    m_level[i] = 1'b0;
                end
            end else begin
                e++;
                rst_flag = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (m_busy[i]) begin
                        if (e == m_done_e[i]) begin
                            m_busy[i]  = 1'b0;
                            m_level[i] = m_tgt[i];
                        end
                    end else if (level_in != m_level[i]) begin
                        plan(i, e, level_in, bounce_en);
                    end
                end
            end
        end
    end

    task automatic mon(input int idx, input logic s, input logic b, input logic dn);
        ev_t ev;
        dn_t dx;
        if (rst_flag) begin
            check("reset_sw", idx, s, 0);
            check("reset_busy", idx, b, 0);
            check("reset_done", idx, dn, 0);
            prev_sw[idx] = s;
            tog[idx] = 0;
            return;
        end
        check("busy", idx, b, m_busy[idx]);
        if (s !== prev_sw[idx]) begin
            tog[idx]++;
            if (swq[idx].size() == 0) begin
                check("sw_unexpected_change", idx, e, -1);
            end else begin
                ev = swq[idx].pop_front();
                check("sw_change_edge", idx, e, ev.e);
                check("sw_change_value", idx, s, ev.v);
            end
        end
        prev_sw[idx] = s;
        while (swq[idx].size() > 0 && swq[idx][0].e < e) begin
            ev = swq[idx].pop_front();
            check("sw_change_missed", idx, -1, ev.e);
        end
        if (dn) begin
            if (dq[idx].size() == 0) begin
                check("done_unexpected", idx, e, -1);
            end else begin
                dx = dq[idx].pop_front();
                check("done_edge", idx, e, dx.e);
                check("sw_toggle_count", idx, tog[idx], dx.tog);
                check("final_sw", idx, s, m_tgt[idx]);
            end
            tog[idx] = 0;
        end
        while (dq[idx].size() > 0 && dq[idx][0].e < e) begin
            dx = dq[idx].pop_front();
            check("done_missed", idx, -1, dx.e);
        end
    endtask

    // Monitor: compares DUT outputs against the queued predictions away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, sw_a, busy_a, done_a);
            mon(1, sw_b, busy_b, done_b);
        end
    end

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (c < IDLE_LIMIT && (m_busy[0] || m_busy[1] || m_level[0] != level_in || m_level[1] != level_in));
        check("idle_reached", 0, (c < IDLE_LIMIT) ? 1 : 0, 1);
    endtask

    // Stimulus.
    initial begin
        bit found;
        reset = 1'b1;
        level_in = 1'b0;
        bounce_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        check("quiet_sw", 0, sw_a, 0);
        check("quiet_busy", 0, busy_a, 0);

        bounce_en = 1'b0;
        level_in = 1'b1;
        wait_idle();
        level_in = 1'b0;
        wait_idle();

        bounce_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            level_in = ~level_in;
            wait_idle();
        end

        if (level_in) begin
            level_in = 1'b0;
            wait_idle();
        end
        level_in = 1'b1;
        repeat (3) @(negedge clk);
        level_in = 1'b0;
        repeat (5) @(negedge clk);
        level_in = 1'b1;
        wait_idle();
        repeat (20) @(negedge clk);
        check("no_second_transition", 0, busy_a, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) level_in = ~level_in;
            if ($urandom_range(0, 19) == 0) bounce_en = 1'($urandom);
        end
        wait_idle();

        found = 1'b0;
        bounce_en = 1'b1;
        for (int t = 0; t < 20 && !found; t++) begin
            level_in = ~level_in;
            for (int c = 0; c < 400 && !found; c++) begin
                @(negedge clk);
                if (busy_a && sw_a !== level_in) found = 1'b1;
            end
            if (found) begin
                reset = 1'b1;
                @(negedge clk);
                level_in = 1'b1;
                reset = 1'b0;
            end
            wait_idle();
        end
        check("boff_reached", 0, found, 1);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            check("sw_queue_drained", i, swq[i].size(), 0);
            check("done_queue_drained", i, dq[i].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/switch_bounce_gen.md
SWITCH_BOUNCE_GEN -- requirements
Module: switch_bounce_gen

Interface
REQ-001 SHALL have parameter TICK_M, default 100_000, meaning clocks per bounce tick (1 ms at 100 MHz); legal range 2 or more.
REQ-002 SHALL have parameter MAX_BOUNCE, default 7, meaning maximum glitch pulses per transition; legal range 0 to 15.
REQ-003 SHALL have parameter SETTLE_TICKS, default 50, meaning ticks sw is held stable after bouncing; must exceed the downstream debounce window of 30 ms.
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port level_in, input, 1 bit: clean target switch level.
REQ-008 SHALL have port bounce_en, input, 1 bit: 1 = emulate bounce, 0 = clean transition.
REQ-009 SHALL have port sw, output, 1 bit: emulated mechanical switch, registered.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a transition completes.

Function
REQ-012 SHALL contain a tick counter that counts 0..TICK_M-1 freely and asserts an internal tick for one cycle at count TICK_M-1 before wrapping to 0.
REQ-013 SHALL contain a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11, which shifts only on tick.
REQ-014 SHALL hold level_reg, the last settled level, and start a transition only in IDLE, on a clock edge where level_in != level_reg.
REQ-015 At transition start, SHALL capture target = level_in, set n = min(lfsr[3:0], MAX_BOUNCE), and force n = 0 if bounce_en = 0.
REQ-016 SHALL implement the states IDLE, BON, BOFF and SETTLE; all outputs are registered.
REQ-017 IDLE -> BON when n > 0, or IDLE -> SETTLE when n = 0; sw = target from the same edge (1-cycle latency from the level_in change).
REQ-018 On entry to BON or BOFF, SHALL load dwell = 1 + lfsr[1:0] (1 to 4 ticks); dwell decrements on each tick, and the phase ends on the tick where dwell = 1.
REQ-019 BON end: if remaining n > 0, go to BOFF with sw = ~target; otherwise go to SETTLE with sw = target.
REQ-020 BOFF end: go to BON with sw = target and decrement n.
REQ-021 SHALL hold SETTLE for exactly SETTLE_TICKS ticks with sw = target.
REQ-022 At the end of SETTLE, SHALL go to IDLE, set level_reg = target, and pulse done for 1 cycle.
REQ-023 Changes of level_in while busy SHALL be ignored; the level present on return to IDLE SHALL be compared against level_reg next cycle.
REQ-024 sw SHALL show exactly n glitch pulses of opposite polarity per transition and SHALL end equal to target.
REQ-025 bounce_en SHALL be sampled only at transition start; changes mid-transition SHALL have no effect.
REQ-026 SHALL NOT restart the tick counter on a transition, so the first phase may end early by up to TICK_M-1 cycles.

Reset
REQ-027 Reset SHALL force: state IDLE, sw = 0, level_reg = 0, busy = 0, done = 0, tick counter = 0, LFSR = SEED.
REQ-028 Reset asserted mid-transition SHALL abort it on the next edge, with no done pulse; after release, level_in = 1 SHALL start a new transition.

Verification
REQ-029 Reset with level_in = 0 -> sw = 0, busy = 0, done = 0 and no activity for 1000 cycles.
REQ-030 TICK_M = 4, SETTLE_TICKS = 3, bounce_en = 0, level_in 0->1 -> sw = 1 one cycle later with no glitches, busy high; done pulses 9 to 12 cycles after the sw edge.
REQ-031 TICK_M = 4, bounce_en = 1, level_in 0->1 -> count of sw rising edges = n + 1 with n <= MAX_BOUNCE; final sw = 1; one done pulse; the reference-model LFSR predicts n and every dwell.
REQ-032 MAX_BOUNCE = 0, bounce_en = 1 -> behaviour identical to the bounce_en = 0 case.
REQ-033 level_in toggles 1->0->1 while busy -> single transition to 1, no second transition because level_reg = 1 matches.
REQ-034 Reset pulsed mid-BOFF -> next cycle sw = 0, busy = 0, done never asserted; after release, level_in = 1 starts a fresh transition.
